// File: rtl/common_pkg.sv
// Shared cbus types: request/response structs, burst length/type and size enums,
// and the 64-bit word and byte-strobe types used by every cbus block.
package common;

    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;

    typedef enum logic [2:0] {
        MSIZE1, MSIZE2, MSIZE4, MSIZE8, MSIZE16, MSIZE32, MSIZE64, MSIZE128
    } msize_t;

    // Encodes beats-1; only power-of-2 burst lengths exist, which WRAP relies on.
    typedef enum logic [7:0] {
        MLEN1   = 8'd0,   MLEN2   = 8'd1,   MLEN4  = 8'd3,  MLEN8  = 8'd7,
        MLEN16  = 8'd15,  MLEN32  = 8'd31,  MLEN64 = 8'd63, MLEN128 = 8'd127,
        MLEN256 = 8'd255
    } mlen_t;

    typedef enum logic [1:0] {
        BURST_FIXED, BURST_INCR, BURST_WRAP, BURST_RESERVED
    } axi_burst_type_t;

    typedef struct packed {
        logic            valid;
        logic            is_write;
        msize_t          size;
        logic [63:0]     addr;
        strobe_t         strobe;
        word_t           data;
        mlen_t           len;
        axi_burst_type_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_burst_addr.sv
// Combinational beat-address generator: word index of beat i for FIXED/INCR/WRAP bursts.
// RESERVED behaves as INCR; indices wrap at the AW-bit boundary.
module cbus_burst_addr
    import common::*;
#(
    parameter int AW = 16
) (
    input  logic [AW-1:0]    w0_i,
    input  mlen_t            len_i,
    input  axi_burst_type_t  burst_i,
    input  logic [7:0]       beat_i,
    output logic [AW-1:0]    idx_o
);

    logic [AW-1:0] mask;
    logic [AW-1:0] step;

    // len is beats-1 and beats is a power of 2, so len doubles as the wrap mask.
    assign mask = AW'(len_i);
    assign step = w0_i + AW'(beat_i);

    always_comb begin
        case (burst_i)
            BURST_FIXED: idx_o = w0_i;
            BURST_WRAP:  idx_o = (w0_i & ~mask) | (step & mask);
            default:     idx_o = step;
        endcase
    end

endmodule

// File: rtl/cbus_mem_responder.sv
// cbus worker backed by a 64-bit-word memory: FIXED/INCR/WRAP bursts, byte-strobed writes,
// programmable first-beat latency. Define CBUS_RESP_STALL_EN to insert LFSR-driven ready gaps.
module cbus_mem_responder
    import common::*;
#(
    parameter int MEM_WORDS = 65536,
    parameter int FIRST_LAT = 2,
    parameter     INIT_FILE = ""
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp,
    output logic       busy
);

    localparam int         AW       = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT_LAST = (FIRST_LAT == 0) ? 4'd0 : 4'(FIRST_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            is_write_q, is_write_d;
    logic [AW-1:0]   w0_q, w0_d;
    mlen_t           len_q, len_d;
    axi_burst_type_t burst_q, burst_d;
    logic [7:0]      beat_q, beat_d;
    logic [3:0]      wait_q, wait_d;
    logic            stall;
    logic            beat_ready;
    logic [7:0]      addr_beat;
    logic [AW-1:0]   mem_idx;
    logic            mem_we;
    word_t           rdata_q;
    word_t           mem_q [MEM_WORDS];
    logic            unused_req;

    assign unused_req = ^{creq.size, creq.addr[63:AW+3], creq.addr[2:0]};

`ifdef CBUS_RESP_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == S_BEAT)
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk) begin
        if (!resetn) lfsr_q <= 8'hA5;
        else         lfsr_q <= lfsr_d;
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // NOTE: every combinational output takes its default first, so no branch can infer a latch.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        w0_d       = w0_q;
        len_d      = len_q;
        burst_d    = burst_q;
        beat_d     = beat_q;
        wait_d     = wait_q;
        beat_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (creq.valid) begin
                    is_write_d = creq.is_write;
                    w0_d       = creq.addr[AW+2:3];
                    len_d      = creq.len;
                    burst_d    = creq.burst;
                    beat_d     = '0;
                    wait_d     = '0;
                    state_d    = (FIRST_LAT == 0) ? S_BEAT : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q == LAT_LAST) begin
                    wait_d  = '0;
                    state_d = S_BEAT;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_BEAT: begin
                beat_ready = !stall;
                if (beat_ready) begin
                    if (beat_q == len_q) state_d = S_DONE;
                    else                 beat_d  = beat_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Writes target the current beat; otherwise the port prefetches the next beat's read.
    assign addr_beat = (state_q == S_BEAT && is_write_q) ? beat_q : beat_d;
    assign mem_we    = resetn && beat_ready && is_write_q;

    cbus_burst_addr #(.AW(AW)) u_burst_addr (
        .w0_i    (w0_d),
        .len_i   (len_d),
        .burst_i (burst_d),
        .beat_i  (addr_beat),
        .idx_o   (mem_idx)
    );

    // NOTE: the array and its read register are never reset; contents survive resetn.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 8; k++)
                if (creq.strobe[k]) mem_q[mem_idx][8*k +: 8] <= creq.data[8*k +: 8];
        end else begin
            rdata_q <= mem_q[mem_idx];
        end
    end

    // NOTE: clocked state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            w0_q       <= '0;
            len_q      <= MLEN1;
            burst_q    <= BURST_FIXED;
            beat_q     <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            w0_q       <= w0_d;
            len_q      <= len_d;
            burst_q    <= burst_d;
            beat_q     <= beat_d;
            wait_q     <= wait_d;
        end
    end

    always_comb begin
        cresp = '0;
        if (beat_ready) begin
            cresp.ready = 1'b1;
            cresp.last  = (beat_q == len_q);
            cresp.data  = is_write_q ? '0 : rdata_q;
        end
    end

    assign busy = (state_q != S_IDLE);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (resetn && (state_q == S_WAIT || state_q == S_BEAT) && !creq.valid)
            $error("cbus_mem_responder: creq.valid dropped mid-burst");
    end
`endif

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Self-checking bench for cbus_mem_responder: directed scenarios plus random bursts
// compared against a byte-tracked memory model and arithmetic burst addressing.
`timescale 1ns/1ps
module tb_cbus_mem_responder;
    import common::*;

    localparam int MEM_WORDS = 1024;
    localparam int FIRST_LAT = 2;
    localparam int TIMEOUT   = 4000;
    localparam int DM_IDX    = 0;  // data = beat index
    localparam int DM_WIDX   = 1;  // data = word index
    localparam int DM_CONST  = 2;
    localparam int DM_RAND   = 3;  // random data, given strobe
    localparam int DM_RANDS  = 4;  // random data and strobe

    logic       clk = 1'b0;
    logic       resetn;
    cbus_req_t  creq;
    cbus_resp_t cresp;
    logic       busy;

    cbus_mem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .FIRST_LAT (FIRST_LAT),
        .INIT_FILE ("")
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .creq   (creq),
        .cresp  (cresp),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    int         total_gaps = 0;
    word_t      model_mem [MEM_WORDS];
    logic [7:0] model_kb  [MEM_WORDS];
    word_t      last_rdata;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_addr(input logic [63:0] addr, input int len, input int burst, input int i);
        int w0, n, base;
        w0 = int'((addr >> 3) % MEM_WORDS);
        n  = len + 1;
        case (burst)
            0: return w0;
            2: begin
                base = (w0 / n) * n;
                return base + (w0 - base + i) % n;
            end
            default: return (w0 + i) % MEM_WORDS;
        endcase
    endfunction

    task automatic run_txn(input bit wr, input logic [63:0] addr, input mlen_t len,
                           input axi_burst_type_t burst, input int dmode, input word_t wconst,
                           input strobe_t strb, input bit b2b, input bit hold, input int abort_beat);
        int      beat = 0;
        int      cyc  = 0;
        int      prev = 0;
        int      idx;
        int      nlen;
        word_t   wd;
        strobe_t ws;
        nlen          = int'(len);
        creq.valid    = 1'b1;
        creq.is_write = wr;
        creq.size     = MSIZE8;
        creq.addr     = addr;
        creq.len      = len;
        creq.burst    = burst;
        creq.strobe   = '0;
        creq.data     = '0;
        while (beat <= nlen) begin
            @(negedge clk);
            cyc++;
            if (cyc > TIMEOUT) begin
                check("timeout_beats", beat, nlen + 1);
                break;
            end
            if (cresp.ready) begin
                idx = model_addr(addr, nlen, int'(burst), beat);
`ifdef CBUS_RESP_STALL_EN
                if (beat == 0) check("first_lat_min", cyc >= FIRST_LAT + 1 + int'(b2b), 1);
`else
                if (beat == 0) check("first_lat", cyc, FIRST_LAT + 1 + int'(b2b));
`endif
                if (beat != 0) total_gaps += cyc - prev - 1;
                prev = cyc;
                check("busy_beat", busy, 1);
                check("last", cresp.last, beat == nlen);
                if (wr) begin
                    check("wr_data_zero", cresp.data, 0);
                    if (beat == abort_beat) begin
                        resetn = 1'b0;
                        @(negedge clk);
                        check("abort_resp", 128'(cresp), 0);
                        check("abort_busy", busy, 0);
                        resetn = 1'b1;
                        return;
                    end
                    case (dmode)
                        DM_IDX:   begin wd = word_t'(beat); ws = strb; end
                        DM_WIDX:  begin wd = word_t'(idx);  ws = strb; end
                        DM_CONST: begin wd = wconst;        ws = strb; end
                        DM_RAND:  begin wd = {$urandom, $urandom}; ws = strb; end
                        default:  begin wd = {$urandom, $urandom}; ws = 8'($urandom); end
                    endcase
                    creq.data   = wd;
                    creq.strobe = ws;
                    for (int k = 0; k < 8; k++)
                        if (ws[k]) begin
                            model_mem[idx][8*k +: 8] = wd[8*k +: 8];
                            model_kb[idx][k] = 1'b1;
                        end
                end else begin
                    last_rdata = cresp.data;
                    if (model_kb[idx] == 8'hFF) check("rd_data", cresp.data, model_mem[idx]);
                end
                beat++;
            end else begin
                check("gap_resp_zero", 128'(cresp), 0);
            end
        end
        @(negedge clk);
        check("done_resp", 128'(cresp), 0);
        check("done_busy", busy, 1);
        if (!hold) begin
            creq.valid = 1'b0;
            @(negedge clk);
            check("idle_busy", busy, 0);
        end
    endtask

    initial begin
        creq   = '0;
        resetn = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) model_kb[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_resp", 128'(cresp), 0);
        check("reset_busy", busy, 0);
        resetn = 1'b1;

        // Single read of a preloaded word.
        run_txn(1, 64'h80, MLEN1, BURST_INCR, DM_CONST, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 0, -1);
        run_txn(0, 64'h80, MLEN1, BURST_INCR, DM_IDX, '0, '0, 0, 0, -1);
        check("single_read", last_rdata, 64'hDEAD_BEEF_0123_4567);

        // INCR write then read back.
        run_txn(1, 64'h100, MLEN8, BURST_INCR, DM_IDX, '0, 8'hFF, 0, 0, -1);
        run_txn(0, 64'h100, MLEN8, BURST_INCR, DM_IDX, '0, '0, 0, 0, -1);
        check("incr_last_beat", last_rdata, 64'd7);

        // WRAP read across a 16-word window starting mid-window.
        run_txn(1, 64'h100, MLEN16, BURST_INCR, DM_WIDX, '0, 8'hFF, 0, 0, -1);
        run_txn(0, 64'h168, MLEN16, BURST_WRAP, DM_IDX, '0, '0, 0, 0, -1);
        check("wrap_last_beat", last_rdata, 64'h2C);

        // Partial-strobe write.
        run_txn(1, 64'h28, MLEN1, BURST_INCR, DM_CONST, 64'h1111_1111_1111_1111, 8'hFF, 0, 0, -1);
        run_txn(1, 64'h28, MLEN1, BURST_INCR, DM_CONST, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 0, -1);
        run_txn(0, 64'h28, MLEN1, BURST_INCR, DM_IDX, '0, '0, 0, 0, -1);
        check("strobe_merge", last_rdata, 64'h1111_1111_FFFF_FFFF);

        // Reset during beat 3 of a 16-beat write, then an immediate new request.
        run_txn(1, 64'h0, MLEN16, BURST_INCR, DM_RAND, '0, 8'hFF, 0, 0, -1);
        run_txn(1, 64'h0, MLEN16, BURST_INCR, DM_RAND, '0, 8'hFF, 0, 0, 3);
        run_txn(0, 64'h0, MLEN16, BURST_INCR, DM_IDX, '0, '0, 0, 0, -1);

        // Back-to-back: valid held through DONE.
        run_txn(0, 64'h100, MLEN8, BURST_INCR, DM_IDX, '0, '0, 0, 1, -1);
        run_txn(0, 64'h110, MLEN4, BURST_WRAP, DM_IDX, '0, '0, 1, 0, -1);

        // Index wrap at the top of the array; upper address bits ignored.
        run_txn(1, 64'h1FE0, MLEN8, BURST_INCR, DM_WIDX, '0, 8'hFF, 0, 0, -1);
        run_txn(0, 64'hFFFF_0000_0000_0000, MLEN4, BURST_INCR, DM_IDX, '0, '0, 0, 0, -1);
        check("modulo_wrap", last_rdata, 64'd3);

        // Random bursts, including FIXED and RESERVED.
        for (int t = 0; t < 40; t++) begin
            mlen_t ml;
            case ($urandom_range(0, 5))
                0: ml = MLEN1;
                1: ml = MLEN2;
                2: ml = MLEN4;
                3: ml = MLEN8;
                4: ml = MLEN16;
                default: ml = MLEN32;
            endcase
            run_txn(1'($urandom), {$urandom, $urandom}, ml,
                    axi_burst_type_t'($urandom_range(0, 3)), DM_RANDS, '0, '0, 0, 0, -1);
        end

`ifdef CBUS_RESP_STALL_EN
        check("stall_gaps_seen", total_gaps > 0, 1);
`else
        check("no_gaps", total_gaps, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
